exception_ctrl: RTL



---
 rtl/exception_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/exception_ctrl.sv
// exception_ctrl: multicycle-MIPS exception sequencer feeding the CP0 EPC/Cause/Status registers.
// Catches synchronous exceptions, enabled interrupts and ERET, then sequences the CP0 writes and PC redirect.
module exception_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h8000_0180,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             instr_done,
    input  logic [31:0]      pc_cur,
    input  logic [31:0]      pc_seq,
    input  logic             exc_ov,
    input  logic             exc_ri,
    input  logic             exc_sys,
    input  logic             irq,
    input  logic             status_ie,
    input  logic             eret,
    input  logic [31:0]      epc_in,
    output logic [31:0]      epc_data,
    output logic             EPCWrite,
    output logic [31:0]      cause_data,
    output logic             CWrite,
    output logic             srst,
    output logic             sset,
    output logic             flush,
    output logic             pc_load,
    output logic [31:0]      pc_next,
    output logic             busy,
    output logic [CNT_W-1:0] exc_cnt
);

    localparam int unsigned CODE_W   = 5;
    localparam logic [CODE_W-1:0] CODE_OV  = 5'd12;
    localparam logic [CODE_W-1:0] CODE_RI  = 5'd10;
    localparam logic [CODE_W-1:0] CODE_SYS = 5'd8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SAVE   = 2'd1,
        S_VECTOR = 2'd2,
        S_RET    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_irq_meta;
    logic                r_irq_s;
    logic [31:0]         r_epc;
    logic [CODE_W-1:0]   r_code;
    logic                r_ip2;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_any_exc;
    logic                w_latch;
    logic [31:0]         w_latch_epc;
    logic [CODE_W-1:0]   w_latch_code;
    logic                w_latch_ip2;

    assign w_any_exc = exc_ov | exc_ri | exc_sys;

    // Two-flop synchronizer for the asynchronous interrupt line.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_irq_meta <= 1'b0;
            r_irq_s    <= 1'b0;
        end else begin
            r_irq_meta <= irq;
            r_irq_s    <= r_irq_meta;
        end
    end

    // Sequencer state register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and strobes; exception beats interrupt beats ERET while idle.
    always_comb begin
        w_next       = r_state;
        flush        = 1'b0;
        EPCWrite     = 1'b0;
        CWrite       = 1'b0;
        srst         = 1'b0;
        sset         = 1'b0;
        pc_load      = 1'b0;
        pc_next      = 32'h0;
        busy         = 1'b0;
        w_latch      = 1'b0;
        w_latch_epc  = 32'h0;
        w_latch_code = '0;
        w_latch_ip2  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_exc) begin
                    flush        = 1'b1;
                    w_latch      = 1'b1;
                    w_latch_epc  = pc_cur;
                    w_latch_code = exc_ov ? CODE_OV : (exc_ri ? CODE_RI : CODE_SYS);
                    w_next       = S_SAVE;
                end else if (instr_done && r_irq_s && status_ie) begin
                    w_latch      = 1'b1;
                    w_latch_epc  = pc_seq;
                    w_latch_ip2  = 1'b1;
                    w_next       = S_SAVE;
                end else if (instr_done && eret) begin
                    flush        = 1'b1;
                    w_next       = S_RET;
                end
            end
            S_SAVE: begin
                busy     = 1'b1;
                EPCWrite = 1'b1;
                CWrite   = 1'b1;
                srst     = 1'b1;
                w_next   = S_VECTOR;
            end
            S_VECTOR: begin
                busy    = 1'b1;
                pc_load = 1'b1;
                pc_next = HANDLER_ADDR;
                w_next  = S_IDLE;
            end
            S_RET: begin
                busy    = 1'b1;
                pc_load = 1'b1;
                pc_next = epc_in;
                sset    = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Capture return address and cause fields at the decision cycle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_epc  <= 32'h0;
            r_code <= '0;
            r_ip2  <= 1'b0;
        end else if (w_latch) begin
            r_epc  <= w_latch_epc;
            r_code <= w_latch_code;
            r_ip2  <= w_latch_ip2;
        end
    end

    // Saturating count of exceptions taken, bumped once per SAVE.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt <= '0;
        end else if (r_state == S_SAVE && r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign epc_data   = r_epc;
    assign cause_data = {21'h0, r_ip2, 3'b000, r_code, 2'b00};
    assign exc_cnt    = r_cnt;

endmodule
